// File: rtl/piso_shift_serializer.sv
// Parallel-in / serial-out shift register with a per-word direction and a valid/ready on
// both sides. The next word can load on the last serial beat, so words stream with no bubble.
module piso_shift_serializer #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_data,
    input  logic             pin_msb_first,
    input  logic             pin_valid,
    output logic             pin_ready,
    input  logic             sin,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_first,
    output logic             sout_last,
    output logic [WIDTH-1:0] par_out
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_dir;

    logic w_shifting;
    logic w_last;
    logic w_beat;
    logic w_pin_ready;
    logic w_load;

    // Handshake decode; pin_ready depends combinationally on sout_ready so a new word can
    // load on the same edge as the final beat of the current one.
    always_comb begin
        w_shifting  = (r_state == ST_SHIFT);
        w_last      = (r_cnt == LAST_CNT);
        w_beat      = w_shifting & sout_ready;
        w_pin_ready = rst_n & ((r_state == ST_IDLE) | (w_shifting & w_last & sout_ready));
        w_load      = pin_valid & w_pin_ready;
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_beat && w_last && !w_load) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift register, bit counter and direction; the counter stops at the last bit and only a
    // load returns it to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_dir   <= 1'b1;
        end else if (w_load) begin
            r_shreg <= pin_data;
            r_cnt   <= {CW{1'b0}};
            r_dir   <= pin_msb_first;
        end else if (w_beat) begin
            if (r_dir) begin
                r_shreg <= {r_shreg[WIDTH-2:0], sin};
            end else begin
                r_shreg <= {sin, r_shreg[WIDTH-1:1]};
            end
            if (!w_last) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end else begin
            r_shreg <= r_shreg;
            r_cnt   <= r_cnt;
            r_dir   <= r_dir;
        end
    end

    // Output decode straight from registered state.
    always_comb begin
        pin_ready  = w_pin_ready;
        sout_valid = w_shifting;
        sout_first = w_shifting & (r_cnt == {CW{1'b0}});
        sout_last  = w_shifting & w_last;
        par_out    = r_shreg;
        if (w_shifting) begin
            sout = r_dir ? r_shreg[WIDTH-1] : r_shreg[0];
        end else begin
            sout = 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_shift_serializer.sv
// Self-checking bench: directed scenarios followed by random traffic, all compared against a
// word-level model that tracks the bits still owed for the current word.
module tb_piso_shift_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pin_data;
    logic         pin_msb_first;
    logic         pin_valid;
    logic         pin_ready;
    logic         sin;
    logic         sout;
    logic         sout_valid;
    logic         sout_ready;
    logic         sout_first;
    logic         sout_last;
    logic [W-1:0] par_out;

    int n_total = 0;
    int n_pass  = 0;

    // Model: bits still to be emitted for the current word, and the register image.
    logic         m_busy = 1'b0;
    logic         m_dir  = 1'b1;
    logic [W-1:0] m_sh   = '0;
    logic         q_bits[$];

    piso_shift_serializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pin_data     (pin_data),
        .pin_msb_first(pin_msb_first),
        .pin_valid    (pin_valid),
        .pin_ready    (pin_ready),
        .sin          (sin),
        .sout         (sout),
        .sout_valid   (sout_valid),
        .sout_ready   (sout_ready),
        .sout_first   (sout_first),
        .sout_last    (sout_last),
        .par_out      (par_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, check outputs, then advance the model
    // to what the coming rising edge must produce.
    task automatic step(input logic v, input logic [W-1:0] d, input logic msb,
                        input logic rdy, input logic s, input logic rn);
        logic e_ready, e_sout, beat, load;
        @(negedge clk);
        rst_n = rn; pin_valid = v; pin_data = d; pin_msb_first = msb;
        sout_ready = rdy; sin = s;
        #1;
        if (!rn) begin
            m_busy = 1'b0; m_dir = 1'b1; m_sh = '0; q_bits.delete();
        end
        e_ready = rn && (!m_busy || (q_bits.size() == 1 && rdy));
        e_sout  = m_busy ? q_bits[0] : 1'b0;
        check("pin_ready",  pin_ready,  e_ready);
        check("sout_valid", sout_valid, m_busy);
        check("sout",       sout,       e_sout);
        check("sout_first", sout_first, m_busy && q_bits.size() == W);
        check("sout_last",  sout_last,  m_busy && q_bits.size() == 1);
        check("par_out",    par_out,    m_sh);
        if (rn) begin
            beat = m_busy && rdy;
            load = v && e_ready;
            if (beat) begin
                void'(q_bits.pop_front());
                if (m_dir) m_sh = {m_sh[W-2:0], s};
                else       m_sh = {s, m_sh[W-1:1]};
                if (q_bits.size() == 0) m_busy = 1'b0;
            end
            if (load) begin
                m_sh = d; m_dir = msb; m_busy = 1'b1;
                q_bits.delete();
                for (int i = 0; i < W; i++) q_bits.push_back(msb ? d[W-1-i] : d[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; pin_valid = 1'b0; pin_data = '0; pin_msb_first = 1'b1;
        sout_ready = 1'b0; sin = 1'b0;
        step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

        // MSB-first and LSB-first of 8'h1E, each finishing in IDLE.
        step(1'b1, 8'h1E, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h1E, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);

        // Backpressure: three stall cycles after the third beat.
        step(1'b1, 8'h1E, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++)
            step(1'b0, 8'hC3, 1'b0, !(i >= 3 && i < 6), 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);

        // Back-to-back 8'hFF then 8'h00 with pin_valid held.
        step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);

        // Cascade fill through sin, both directions.
        step(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        check("fill_msb", par_out, 8'hFF);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        check("fill_lsb", par_out, 8'hFF);

        // Reset three beats into a word, then release.
        step(1'b1, 8'h1E, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 199) != 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
